gray_frame_sequencer: RTL and testbench

- AXI4-Lite master that sequences the convert-to-gray HLS core through a batch of frames.
- Accepts one command (rows, cols, frame count) and programs the core's ROWS/COLS argument registers.
- Per frame: sets ap_start, waits for ap_done, counts completed frames, then starts the next frame until the batch ends.
- Sits between the system control logic and the core's s_axi_CONTROL_BUS slave (5-bit address, 32-bit data).

---
 rtl/gray_frame_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_gray_frame_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_frame_sequencer.sv
// gray_frame_sequencer
//   AXI4-Lite master that drives the convert-to-gray HLS core through a batch
//   of frames. It takes one command (rows, cols, frame count) and programs the
//   ROWS/COLS argument registers. For each frame it sets ap_start and waits
//   for ap_done, then starts the next frame until the batch is complete.
//
// Optional build macro: IRQ_WAIT_EN
//   Defined   : enables GIE/IER once per batch and waits on `interrupt`
//               instead of polling. Each frame then reads AP_CTRL and
//               toggle-clears ISR. GIE is switched off before the sequencer
//               returns to idle.
//   Undefined : polls AP_CTRL every POLL_GAP cycles; `interrupt` is ignored.
//
// Ports
//   aclk, areset                 clock, synchronous active-high reset
//   cmd_valid/ready/rows/cols/frames  command handshake (ready only in idle)
//   busy                         high whenever a batch is in progress
//   frame_done, batch_done       one-cycle completion pulses
//   frames_cnt                   frames completed in the current/last batch
//   err                          sticky, cleared by the next accepted command
//   m_axi_*                      AXI4-Lite master towards s_axi_CONTROL_BUS
//   interrupt                    core interrupt (IRQ_WAIT_EN builds only)
module gray_frame_sequencer #(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] ROWS_OFF = 5'h14,
  parameter logic [ADDR_W-1:0] COLS_OFF = 5'h1C,
  parameter int                POLL_GAP = 16,
  parameter int                TIMEOUT  = 1048576
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_rows,
  input  logic [15:0]       cmd_cols,
  input  logic [15:0]       cmd_frames,
  output logic              busy,
  output logic              frame_done,
  output logic              batch_done,
  output logic [15:0]       frames_cnt,
  output logic              err,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic              interrupt
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ROWS, S_WR_COLS, S_WR_GIE, S_WR_IER, S_WR_START, S_GAP,
    S_IRQ_WAIT, S_RD_CTRL, S_WR_ISR, S_WR_GIE_OFF, S_FRAME_END, S_FAIL
  } state_t;

  state_t            state, state_nxt, wr_next;
  logic              aw_sent, w_sent, ar_sent;
  logic              is_wr, wr_fin, rd_fin, accept, to_hit, last_frame;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [15:0]       rows_q, cols_q, frames_q;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              unused_sig;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept     = cmd_valid & cmd_ready;
  assign wr_fin     = is_wr & m_axi_bvalid;
  assign rd_fin     = (state == S_RD_CTRL) & m_axi_rvalid;
  assign to_hit     = (to_cnt >= TO_W'(TIMEOUT));
  assign last_frame = (sat_inc16(frames_cnt) == frames_q);
  // rdata is only partly inspected; interrupt is unused in polling builds.
  assign unused_sig = ^{m_axi_rdata, interrupt};

  // State register
  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    wr_next   = S_IDLE;
    case (state)
      S_IDLE:     if (accept) state_nxt = (cmd_frames == 16'd0) ? S_IDLE : S_WR_ROWS;
      S_WR_ROWS:  wr_next = S_WR_COLS;
`ifdef IRQ_WAIT_EN
      S_WR_COLS:  wr_next = S_WR_GIE;
      S_WR_GIE:   wr_next = S_WR_IER;
      S_WR_IER:   wr_next = S_WR_START;
      S_WR_START: wr_next = S_IRQ_WAIT;
      S_IRQ_WAIT: begin
        if (interrupt)   state_nxt = S_RD_CTRL;
        else if (to_hit) state_nxt = S_FAIL;
      end
      S_RD_CTRL:  if (rd_fin) state_nxt = (m_axi_rresp != 2'b00) ? S_FAIL : S_WR_ISR;
      S_WR_ISR:   wr_next = S_FRAME_END;
      S_WR_GIE_OFF: wr_next = S_IDLE;
      S_FRAME_END: state_nxt = last_frame ? S_WR_GIE_OFF : S_WR_START;
`else
      S_WR_COLS:  wr_next = S_WR_START;
      S_WR_START: wr_next = S_GAP;
      S_GAP: begin
        if (to_hit)                               state_nxt = S_FAIL;
        else if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_nxt = S_RD_CTRL;
      end
      // ap_done wins over a timeout that expired during the read.
      S_RD_CTRL: begin
        if (rd_fin) begin
          if (m_axi_rresp != 2'b00) state_nxt = S_FAIL;
          else if (m_axi_rdata[1])  state_nxt = S_FRAME_END;
          else if (to_hit)          state_nxt = S_FAIL;
          else                      state_nxt = S_GAP;
        end
      end
      S_FRAME_END: state_nxt = last_frame ? S_IDLE : S_WR_START;
`endif
      S_FAIL:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (wr_fin) state_nxt = (m_axi_bresp != 2'b00) ? S_FAIL : wr_next;
  end

  // Output decode: every write state maps to one register access; valids
  // drop once their own handshake has been recorded in the *_sent flags.
  always_comb begin
    is_wr   = 1'b1;
    wr_addr = '0;
    wr_data = 32'd0;
    case (state)
      S_WR_ROWS:    begin wr_addr = ROWS_OFF;     wr_data = {16'd0, rows_q}; end
      S_WR_COLS:    begin wr_addr = COLS_OFF;     wr_data = {16'd0, cols_q}; end
      S_WR_GIE:     begin wr_addr = ADDR_W'(4);   wr_data = 32'd1; end
      S_WR_IER:     begin wr_addr = ADDR_W'(8);   wr_data = 32'd1; end
      S_WR_START:   begin wr_addr = ADDR_W'(0);   wr_data = 32'd1; end
      S_WR_ISR:     begin wr_addr = ADDR_W'(12);  wr_data = 32'd1; end
      S_WR_GIE_OFF: begin wr_addr = ADDR_W'(4);   wr_data = 32'd0; end
      default:      is_wr = 1'b0;
    endcase
    cmd_ready     = (state == S_IDLE);
    busy          = (state != S_IDLE);
    m_axi_awaddr  = wr_addr;
    m_axi_wdata   = wr_data;
    m_axi_wstrb   = 4'hF;
    m_axi_awvalid = is_wr & ~aw_sent;
    m_axi_wvalid  = is_wr & ~w_sent;
    m_axi_bready  = is_wr;
    m_axi_araddr  = '0;
    m_axi_arvalid = (state == S_RD_CTRL) & ~ar_sent;
    m_axi_rready  = (state == S_RD_CTRL);
  end

  // Handshake tracking, counters and status
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_sent    <= 1'b0;
      w_sent     <= 1'b0;
      ar_sent    <= 1'b0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      frames_cnt <= 16'd0;
      err        <= 1'b0;
      frame_done <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      if (m_axi_bvalid && m_axi_bready) begin
        aw_sent <= 1'b0;
        w_sent  <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) aw_sent <= 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_sent  <= 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready)        ar_sent <= 1'b0;
      else if (m_axi_arvalid && m_axi_arready) ar_sent <= 1'b1;

      // Held at zero through WR_START so counting begins as it completes.
      if (state == S_WR_START) to_cnt <= '0;
      else if (!to_hit)        to_cnt <= to_cnt + 1'b1;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;

      if (accept)                    frames_cnt <= 16'd0;
      else if (state == S_FRAME_END) frames_cnt <= sat_inc16(frames_cnt);

      if (accept)                                        err <= 1'b0;
      else if (state_nxt == S_FAIL && state != S_FAIL)   err <= 1'b1;

      frame_done <= (state == S_FRAME_END);
      // Every return to IDLE from a busy state ends a batch.
      batch_done <= (accept && cmd_frames == 16'd0) ||
                    (state != S_IDLE && state_nxt == S_IDLE);
    end
  end

  // Command latch
  always_ff @(posedge aclk) begin
    if (accept) begin
      rows_q   <= cmd_rows;
      cols_q   <= cmd_cols;
      frames_q <= cmd_frames;
    end
  end

endmodule

// File: tb/tb_gray_frame_sequencer.sv
module tb_gray_frame_sequencer;
  localparam int ADDR_W   = 5;
  localparam int POLL_GAP = 8;
  localparam int TIMEOUT  = 200;
  localparam int DONE_LAT = 100;
`ifdef IRQ_WAIT_EN
  localparam int IRQ = 1;
`else
  localparam int IRQ = 0;
`endif

  logic aclk = 1'b0, areset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_rows = '0, cmd_cols = '0, cmd_frames = '0;
  logic busy, frame_done, batch_done, err;
  logic [15:0] frames_cnt;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp, m_axi_rresp;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic m_axi_rvalid, m_axi_rready, interrupt;

  always #5 aclk = ~aclk;

  gray_frame_sequencer #(.ADDR_W(ADDR_W), .ROWS_OFF(5'h14), .COLS_OFF(5'h1C),
                         .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_frames(cmd_frames),
    .busy(busy), .frame_done(frame_done), .batch_done(batch_done),
    .frames_cnt(frames_cnt), .err(err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .interrupt(interrupt)
  );

  // Slave / core model controls (written by the stimulus process only)
  int         max_dly    = 0;
  logic       never_done = 1'b0;
  logic       fail_en    = 1'b0;
  logic [4:0] fail_addr  = 5'h00;

  // Slave / core model state
  logic        aw_have, w_have, ar_have;
  logic [4:0]  aw_addr_q, ar_addr_q;
  logic [31:0] w_data_q;
  int          aw_dly, w_dly, r_dly, tmr;
  logic        run, ap_done, isr, gie, ier;
  logic [31:0] wl_addr[$], wl_data[$];
  int          n_rd = 0;

  assign interrupt = gie & ier & isr;
  assign m_axi_rresp = 2'b00;

  always @(posedge aclk) begin
    if (areset) begin
      m_axi_awready <= 0; m_axi_wready <= 0; m_axi_bvalid <= 0; m_axi_bresp <= 0;
      m_axi_arready <= 0; m_axi_rvalid <= 0; m_axi_rdata <= 0;
      aw_have <= 0; w_have <= 0; ar_have <= 0; aw_dly <= 0; w_dly <= 0; r_dly <= 0;
      run <= 0; tmr <= 0; ap_done <= 0; isr <= 0; gie <= 0; ier <= 0;
    end else begin
      // core done timer
      if (run) begin
        if (tmr == 0) begin ap_done <= 1; isr <= 1; run <= 0; end
        else tmr <= tmr - 1;
      end
      // AW
      if (m_axi_awready && m_axi_awvalid) begin
        m_axi_awready <= 0; aw_have <= 1; aw_addr_q <= m_axi_awaddr;
        aw_dly <= $urandom_range(0, max_dly);
      end else if (m_axi_awvalid && !aw_have && !m_axi_awready) begin
        if (aw_dly == 0) m_axi_awready <= 1; else aw_dly <= aw_dly - 1;
      end
      // W
      if (m_axi_wready && m_axi_wvalid) begin
        m_axi_wready <= 0; w_have <= 1; w_data_q <= m_axi_wdata;
        w_dly <= $urandom_range(0, max_dly);
      end else if (m_axi_wvalid && !w_have && !m_axi_wready) begin
        if (w_dly == 0) m_axi_wready <= 1; else w_dly <= w_dly - 1;
      end
      // B + register side effects
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 0; aw_have <= 0; w_have <= 0;
      end else if (aw_have && w_have && !m_axi_bvalid) begin
        m_axi_bvalid <= 1;
        wl_addr.push_back({27'd0, aw_addr_q});
        wl_data.push_back(w_data_q);
        if (fail_en && aw_addr_q == fail_addr) m_axi_bresp <= 2'b10;
        else begin
          m_axi_bresp <= 2'b00;
          case (aw_addr_q)
            5'h00: if (w_data_q[0] && !never_done) begin run <= 1; tmr <= DONE_LAT; end
            5'h04: gie <= w_data_q[0];
            5'h08: ier <= w_data_q[0];
            5'h0C: if (w_data_q[0]) isr <= 0;
            default: ;
          endcase
        end
      end
      // AR / R
      if (m_axi_arready && m_axi_arvalid) begin
        m_axi_arready <= 0; ar_have <= 1; ar_addr_q <= m_axi_araddr;
        r_dly <= $urandom_range(0, max_dly);
      end else if (m_axi_arvalid && !ar_have && !m_axi_arready) begin
        m_axi_arready <= 1;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 0; ar_have <= 0;
      end else if (ar_have && !m_axi_rvalid) begin
        if (r_dly == 0) begin
          m_axi_rvalid <= 1; n_rd <= n_rd + 1;
          m_axi_rdata <= (ar_addr_q == 5'h00) ? {30'd0, ap_done, 1'b0} : 32'd0;
          if (ar_addr_q == 5'h00 && ap_done) ap_done <= 0;
        end else r_dly <= r_dly - 1;
      end
    end
  end

  // Protocol monitor: valid held until handshake, payload stable; pulse counts
  int viol = 0, n_fd = 0, n_bd = 0;
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [ADDR_W-1:0] p_awa, p_ara;
  logic [31:0] p_wd;
  always @(posedge aclk) begin
    if (areset) begin
      p_awv <= 0; p_wv <= 0; p_arv <= 0; p_awr <= 0; p_wr <= 0; p_arr <= 0;
    end else begin
      if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awa)) viol <= viol + 1;
      if (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata != p_wd)) viol <= viol + 1;
      if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_ara)) viol <= viol + 1;
      p_awv <= m_axi_awvalid; p_awr <= m_axi_awready; p_awa <= m_axi_awaddr;
      p_wv <= m_axi_wvalid; p_wr <= m_axi_wready; p_wd <= m_axi_wdata;
      p_arv <= m_axi_arvalid; p_arr <= m_axi_arready; p_ara <= m_axi_araddr;
      if (frame_done) n_fd <= n_fd + 1;
      if (batch_done) n_bd <= n_bd + 1;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int count_log(input int from, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    for (int i = from; i < wl_addr.size(); i++)
      if (wl_addr[i] == a && wl_data[i] == d) n++;
    return n;
  endfunction

  task automatic send_cmd(input logic [15:0] r, input logic [15:0] c, input logic [15:0] f);
    int guard = 0;
    while (!cmd_ready && guard < 2000) begin @(negedge aclk); guard++; end
    check("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_rows = r; cmd_cols = c; cmd_frames = f; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_batch(output int cyc);
    cyc = 0;
    while (!batch_done && cyc < 5000) begin @(negedge aclk); cyc++; end
    check("batch_done_seen", batch_done, 1);
  endtask

  initial begin
    int base, fd0, bd0, rd0, cyc;
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_frames_cnt", frames_cnt, 0);
    check("rst_err", err, 0);
    check("rst_pulses", {frame_done, batch_done}, 0);
    check("wstrb", m_axi_wstrb, 4'hF);

    // Single frame 480x640
    base = wl_addr.size(); fd0 = n_fd; bd0 = n_bd; rd0 = n_rd;
    send_cmd(16'd480, 16'd640, 16'd1);
    check("aw_latency", m_axi_awvalid, 1);
    check("aw_first_addr", m_axi_awaddr, 5'h14);
    wait_batch(cyc);
    check("f1_nwrites", wl_addr.size() - base, 3 + 4 * IRQ);
    check("f1_rows", {wl_addr[base], wl_data[base]}, {32'h14, 32'd480});
    check("f1_cols", {wl_addr[base+1], wl_data[base+1]}, {32'h1C, 32'd640});
    check("f1_start", count_log(base, 32'h0, 32'h1), 1);
    check("f1_gie_ier", {count_log(base, 32'h4, 32'h1), count_log(base, 32'h8, 32'h1),
                         count_log(base, 32'hC, 32'h1), count_log(base, 32'h4, 32'h0)},
          {4{IRQ}});
    check("f1_reads", (IRQ != 0) ? (n_rd - rd0 == 1) : (n_rd - rd0 >= 2), 1);
    check("f1_frames_cnt", frames_cnt, 1);
    check("f1_err", err, 0);
    @(negedge aclk);
    check("f1_frame_done", n_fd - fd0, 1);
    check("f1_batch_done", n_bd - bd0, 1);

    // Three frames: args written once, ap_start thrice
    base = wl_addr.size(); fd0 = n_fd;
    send_cmd(16'd10, 16'd20, 16'd3);
    check("f3_busy", busy, 1);
    wait_batch(cyc);
    check("f3_rows_once", count_log(base, 32'h14, 32'd10), 1);
    check("f3_cols_once", count_log(base, 32'h1C, 32'd20), 1);
    check("f3_starts", count_log(base, 32'h0, 32'h1), 3);
    check("f3_isr", count_log(base, 32'hC, 32'h1), 3 * IRQ);
    check("f3_frames_cnt", frames_cnt, 3);
    @(negedge aclk);
    check("f3_frame_done", n_fd - fd0, 3);
    check("f3_cmd_ready", cmd_ready, 1);

    // Zero frames: immediate completion, no bus traffic
    base = wl_addr.size(); rd0 = n_rd;
    send_cmd(16'd5, 16'd5, 16'd0);
    check("f0_batch_done", batch_done, 1);
    check("f0_frames_cnt", frames_cnt, 0);
    check("f0_busy", busy, 0);
    repeat (5) @(negedge aclk);
    check("f0_no_traffic", (wl_addr.size() - base) + (n_rd - rd0), 0);
    check("f0_pulse_len", batch_done, 0);

    // Error response on the COLS write
    base = wl_addr.size();
    fail_en = 1'b1; fail_addr = 5'h1C;
    send_cmd(16'd7, 16'd9, 16'd1);
    wait_batch(cyc);
    check("bresp_err", err, 1);
    check("bresp_no_start", count_log(base, 32'h0, 32'h1), 0);
    check("bresp_frames_cnt", frames_cnt, 0);
    fail_en = 1'b0;
    send_cmd(16'd7, 16'd9, 16'd1);
    check("err_cleared", err, 0);
    wait_batch(cyc);
    check("retry_ok", {err, frames_cnt}, {1'b0, 16'd1});

    // Timeout: done never arrives
    never_done = 1'b1;
    send_cmd(16'd1, 16'd1, 16'd1);
    wait_batch(cyc);
    check("to_err", err, 1);
    check("to_not_early", cyc >= TIMEOUT, 1);
    check("to_bound", cyc <= TIMEOUT + POLL_GAP + 40, 1);

    // Reset in the middle of an operation
    send_cmd(16'd1, 16'd1, 16'd1);
    cyc = 0;
    while (!(m_axi_arvalid || (IRQ != 0 && busy && cyc > 30)) && cyc < 1000) begin
      @(negedge aclk); cyc++;
    end
    check("midrst_reached", busy, 1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    check("midrst_ctrl", {busy, cmd_ready, err, frame_done, batch_done}, 5'b01000);
    check("midrst_cnt", frames_cnt, 0);
    never_done = 1'b0;

    // Random ready/valid delays on the slave
    max_dly = 5;
    base = wl_addr.size(); fd0 = n_fd;
    send_cmd(16'd100, 16'd200, 16'd2);
    wait_batch(cyc);
    check("rnd_rows", count_log(base, 32'h14, 32'd100), 1);
    check("rnd_cols", count_log(base, 32'h1C, 32'd200), 1);
    check("rnd_starts", count_log(base, 32'h0, 32'h1), 2);
    check("rnd_status", {err, frames_cnt}, {1'b0, 16'd2});
    @(negedge aclk);
    check("rnd_frame_done", n_fd - fd0, 2);
    check("axi_stability", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
